// File: rtl/idelay_load_arbiter.sv
// idelay_load_arbiter
//   Shares one IDELAY variable-load port between the HS400 tuning engine
//   (tun_*) and the manual/register override path (man_*). Each granted
//   request is sequenced as LOAD -> SETTLE -> (CHECK) -> ACK. The sequence
//   ends with a one-cycle ack to the granted side.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   tun_req/tun_val       tuning request and requested tap
//   tun_ack/tun_err       tuning done pulse, error qualifier (valid with ack)
//   man_req/man_val       manual request and requested tap
//   man_ack/man_err       manual done pulse, error qualifier (valid with ack)
//   busy                  high whenever the FSM is not IDLE
//   cur_val               last tap value committed without error
//   cntval_in/cntval_load IDELAY CNTVALUEIN / LD (LD is a one-cycle pulse)
//   cntval_out            IDELAY CNTVALUEOUT readback
//
// Configuration macro: IDLY_READBACK_CHK_EN
//   defined   -> readback compare after settling, with up to RETRY_MAX reloads
//   undefined -> no compare; SETTLE goes straight to ACK and err is tied 0
module idelay_load_arbiter #(
    parameter int CNT_W      = 5,
    parameter int SETTLE_CYC = 4,
    parameter int RETRY_MAX  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tun_req,
    input  logic [CNT_W-1:0] tun_val,
    output logic             tun_ack,
    output logic             tun_err,
    input  logic             man_req,
    input  logic [CNT_W-1:0] man_val,
    output logic             man_ack,
    output logic             man_err,
    output logic             busy,
    output logic [CNT_W-1:0] cur_val,
    output logic [CNT_W-1:0] cntval_in,
    output logic             cntval_load,
    input  logic [CNT_W-1:0] cntval_out
);

    localparam int SC_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_ACK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;       // also drives cntval_in
    logic [CNT_W-1:0] cur_q, cur_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic             gid_q, gid_d;       // 0 = tuning, 1 = manual
    logic             rr_q, rr_d;         // side that wins a tie
    logic             pick_man;

`ifdef IDLY_READBACK_CHK_EN
    localparam int AT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [AT_W-1:0] att_q, att_d;
    logic            err_q, err_d;
`else
    logic unused_cntval;
    assign unused_cntval = ^cntval_out;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            gid_q   <= 1'b0;
            rr_q    <= 1'b0;
`ifdef IDLY_READBACK_CHK_EN
            att_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
`ifdef IDLY_READBACK_CHK_EN
            att_q   <= att_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        gid_d    = gid_q;
        rr_d     = rr_q;
        pick_man = man_req && (!tun_req || rr_q);
`ifdef IDLY_READBACK_CHK_EN
        att_d    = att_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tun_req || man_req) begin
                    gid_d   = pick_man;
                    tgt_d   = pick_man ? man_val : tun_val;
                    // Tie priority goes to the side that did not just win.
                    rr_d    = ~pick_man;
`ifdef IDLY_READBACK_CHK_EN
                    att_d   = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = SC_W'(SETTLE_CYC - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
`ifdef IDLY_READBACK_CHK_EN
                    state_d = S_CHECK;
`else
                    cur_d   = tgt_q;
                    state_d = S_ACK;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef IDLY_READBACK_CHK_EN
            S_CHECK: begin
                if (cntval_out == tgt_q) begin
                    err_d   = 1'b0;
                    cur_d   = tgt_q;
                    state_d = S_ACK;
                end else if (int'(att_q) < RETRY_MAX) begin
                    att_d   = att_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
`endif
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state_q != S_IDLE);
        cntval_load = (state_q == S_LOAD);
        cntval_in   = tgt_q;
        cur_val     = cur_q;
        tun_ack     = (state_q == S_ACK) && !gid_q;
        man_ack     = (state_q == S_ACK) &&  gid_q;
`ifdef IDLY_READBACK_CHK_EN
        tun_err     = tun_ack && err_q;
        man_err     = man_ack && err_q;
`else
        tun_err     = 1'b0;
        man_err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_idelay_load_arbiter.sv
module tb_idelay_load_arbiter;

    localparam int CNT_W = 5;
    localparam int SC    = 4;
    localparam int RM    = 2;
`ifdef IDLY_READBACK_CHK_EN
    localparam bit CHK   = 1'b1;
    localparam int LAT   = SC + 3;
`else
    localparam bit CHK   = 1'b0;
    localparam int LAT   = SC + 2;
`endif
    localparam int RLAT  = SC + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tun_req = 1'b0, man_req = 1'b0;
    logic [CNT_W-1:0] tun_val = '0, man_val = '0;
    logic             tun_ack, tun_err, man_ack, man_err, busy, cntval_load;
    logic [CNT_W-1:0] cur_val, cntval_in, cntval_out;

    idelay_load_arbiter #(.CNT_W(CNT_W), .SETTLE_CYC(SC), .RETRY_MAX(RM)) dut (
        .clk(clk), .rst(rst),
        .tun_req(tun_req), .tun_val(tun_val), .tun_ack(tun_ack), .tun_err(tun_err),
        .man_req(man_req), .man_val(man_val), .man_ack(man_ack), .man_err(man_err),
        .busy(busy), .cur_val(cur_val),
        .cntval_in(cntval_in), .cntval_load(cntval_load), .cntval_out(cntval_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // IDELAY model: loads on LD unless the tap is stuck at 0
    logic [CNT_W-1:0] tap = '0;
    bit               stuck = 1'b0;
    always @(posedge clk) if (cntval_load) tap <= cntval_in;
    assign cntval_out = stuck ? '0 : tap;

    int loads = 0;
    int last_load_cyc = -1;
    always @(negedge clk) if (cntval_load) begin loads++; last_load_cyc = cyc; end

    typedef struct {
        bit               man;
        bit               err;
        int               cyc;
        logic [CNT_W-1:0] cur;
    } exp_t;
    exp_t q[$];
    logic [CNT_W-1:0] exp_cur = '0;

    int checks = 0;
    int errors = 0;

    // Scoreboard monitor: every ack must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ((tun_err && !tun_ack) || (man_err && !man_ack)) begin
            errors++;
            $display("FAIL err_without_ack: cyc=%0d tun_err=%b man_err=%b want 0", cyc, tun_err, man_err);
        end
        if (tun_ack || man_ack) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: cyc=%0d tun_ack=%b man_ack=%b", cyc, tun_ack, man_ack);
            end else begin
                e = q.pop_front();
                if ({man_ack, tun_ack} !== {e.man, !e.man}) begin
                    errors++;
                    $display("FAIL ack_side: got man/tun=%b%b want %b%b", man_ack, tun_ack, e.man, !e.man);
                end
                checks++;
                if ((e.man ? man_err : tun_err) !== e.err || (e.man ? tun_err : man_err) !== 1'b0) begin
                    errors++;
                    $display("FAIL ack_err: got tun_err=%b man_err=%b want err=%b on side man=%b",
                             tun_err, man_err, e.err, e.man);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL ack_cycle: got %0d want %0d", cyc, e.cyc);
                end
                checks++;
                if (cur_val !== e.cur) begin
                    errors++;
                    $display("FAIL ack_cur_val: got %0d want %0d", cur_val, e.cur);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit man, input bit err, input int at, input logic [CNT_W-1:0] val);
        exp_t e;
        if (!err) exp_cur = val;
        e.man = man; e.err = err; e.cyc = at; e.cur = exp_cur;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin tick(1); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: queue=%0d busy=%b after %0d cycles", nm, q.size(), busy, n);
        end
    endtask

    task automatic check_cleared(input string nm, input logic [CNT_W-1:0] want_cur);
        checks++;
        if ({busy, cntval_load, tun_ack, tun_err, man_ack, man_err} !== 6'b0
            || cntval_in !== '0 || cur_val !== want_cur) begin
            errors++;
            $display("FAIL %s: busy=%b ld=%b acks=%b%b errs=%b%b cntval_in=%0d cur_val=%0d want all 0 cur=%0d",
                     nm, busy, cntval_load, tun_ack, man_ack, tun_err, man_err, cntval_in, cur_val, want_cur);
        end
    endtask

    task automatic test_reset;
        tick(2);
        check_cleared("reset_hold", '0);
        rst = 1'b1;
        tick(2);
        check_cleared("reset_release", '0);
    endtask

    task automatic test_single_tun;
        int t0, l0;
        l0 = loads;
        tun_val = 13; tun_req = 1'b1;
        t0 = cyc;
        push(1'b0, 1'b0, t0 + LAT, 13);
        tick(1);
        tun_req = 1'b0;
        drain("single");
        checks++;
        if (loads - l0 !== 1 || last_load_cyc !== t0 + 1) begin
            errors++;
            $display("FAIL single_load: pulses=%0d at %0d want 1 at %0d", loads - l0, last_load_cyc, t0 + 1);
        end
    endtask

    task automatic test_reset_midrun;
        tun_val = 3; tun_req = 1'b1;
        tick(1);
        tun_req = 1'b0;
        tick(3);
        rst = 1'b0;
        #1;
        check_cleared("reset_midrun", '0);
        exp_cur = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic pair(input logic [CNT_W-1:0] tv, input logic [CNT_W-1:0] mv);
        int t0;
        tun_val = tv; man_val = mv;
        tun_req = 1'b1; man_req = 1'b1;
        t0 = cyc;
        push(1'b0, 1'b0, t0 + LAT, tv);
        push(1'b1, 1'b0, t0 + 2 * LAT + 1, mv);
        tick(LAT + 1);
        tun_req = 1'b0;
        tick(LAT + 1);
        man_req = 1'b0;
        drain("contention");
    endtask

    task automatic test_contention;
        pair(5, 20);
        pair(11, 22);
    endtask

    task automatic test_stuck;
        int t0, l0, nl;
        bit e;
        stuck = 1'b1;
        l0 = loads;
        man_val = 9; man_req = 1'b1;
        t0 = cyc;
        e  = CHK;
        nl = CHK ? RM + 1 : 1;
        push(1'b1, e, t0 + LAT + (CHK ? RM * RLAT : 0), 9);
        tick(1);
        man_req = 1'b0;
        drain("stuck");
        checks++;
        if (loads - l0 !== nl) begin
            errors++;
            $display("FAIL stuck_loads: got %0d want %0d", loads - l0, nl);
        end
        stuck = 1'b0;
    endtask

    task automatic test_abort;
        int t0;
        tun_val = 17; tun_req = 1'b1;
        tick(1);
        tun_req = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        check_cleared("abort_reset", '0);
        exp_cur = '0;
        tick(10);
        checks++;
        if (cntval_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: ld=%b busy=%b want 0", cntval_load, busy);
        end
        rst = 1'b1;
        tick(1);
        man_val = 7; man_req = 1'b1;
        t0 = cyc;
        push(1'b1, 1'b0, t0 + LAT, 7);
        tick(1);
        man_req = 1'b0;
        drain("abort_followup");
    endtask

    task automatic test_same_tap;
        int t0, l0;
        l0 = loads;
        man_val = exp_cur; man_req = 1'b1;
        t0 = cyc;
        push(1'b1, 1'b0, t0 + LAT, exp_cur);
        tick(1);
        man_req = 1'b0;
        drain("same_tap");
        checks++;
        if (loads - l0 !== 1) begin
            errors++;
            $display("FAIL same_tap_load: pulses=%0d want 1", loads - l0);
        end
    endtask

    initial begin
        test_reset();
        test_single_tun();
        test_reset_midrun();
        test_contention();
        test_stuck();
        test_abort();
        test_same_tap();
        tick(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: %0d acks never seen", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
